// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counter BHT plus a direct-mapped BTB.
// Lookups return a registered prediction one cycle later; execute trains both tables.
module branch_predictor #(
  parameter int unsigned BHT_IDX_BITS = 6,
  parameter int unsigned BTB_IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lkp_valid,
  input  logic        lkp_stall,
  input  logic [31:0] lkp_pc,
  input  logic        flush,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int BhtEntries = 1 << BHT_IDX_BITS;
  localparam int BtbEntries = 1 << BTB_IDX_BITS;
  localparam int TagBits    = 30 - BTB_IDX_BITS;

  logic [1:0]         bht_q       [BhtEntries];
  logic               btb_valid_q [BtbEntries];
  logic [TagBits-1:0] btb_tag_q   [BtbEntries];
  logic [31:0]        btb_tgt_q   [BtbEntries];

  logic [BHT_IDX_BITS-1:0] lkp_bht_idx, upd_bht_idx;
  logic [BTB_IDX_BITS-1:0] lkp_btb_idx, upd_btb_idx;
  logic [TagBits-1:0]      lkp_tag, upd_tag;
  logic                    btb_hit, taken_c, capture;
  logic [31:0]             target_c, seq_pc;
  logic                    unused_pc_bits;

  assign lkp_bht_idx = lkp_pc[BHT_IDX_BITS+1:2];
  assign upd_bht_idx = upd_pc[BHT_IDX_BITS+1:2];
  assign lkp_btb_idx = lkp_pc[BTB_IDX_BITS+1:2];
  assign upd_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
  assign lkp_tag     = lkp_pc[31:BTB_IDX_BITS+2];
  assign upd_tag     = upd_pc[31:BTB_IDX_BITS+2];
  assign unused_pc_bits = ^{lkp_pc[1:0], upd_pc[1:0]};

  // Fall-through ignores pc[1:0]; the +1 on the word address wraps naturally.
  assign seq_pc  = {lkp_pc[31:2] + 30'd1, 2'b00};
  assign capture = lkp_valid && (!lkp_stall || flush);

  always_comb begin
    btb_hit  = btb_valid_q[lkp_btb_idx] && (btb_tag_q[lkp_btb_idx] == lkp_tag);
    taken_c  = bht_q[lkp_bht_idx][1] && btb_hit;
    target_c = taken_c ? btb_tgt_q[lkp_btb_idx] : seq_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= 32'h0;
    end else if (capture) begin
      pred_valid  <= 1'b1;
      pred_taken  <= taken_c;
      pred_target <= target_c;
    end else if (flush || !lkp_stall) begin
      pred_valid  <= 1'b0;
    end
  end

  // Reads above see pre-edge state, so same-edge lookup/update is read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BhtEntries; i++) bht_q[i] <= 2'b01;
      for (int i = 0; i < BtbEntries; i++) btb_valid_q[i] <= 1'b0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (bht_q[upd_bht_idx] != 2'b11) bht_q[upd_bht_idx] <= bht_q[upd_bht_idx] + 2'b01;
        btb_valid_q[upd_btb_idx] <= 1'b1;
      end else if (bht_q[upd_bht_idx] != 2'b00) begin
        bht_q[upd_bht_idx] <= bht_q[upd_bht_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_tag_q[upd_btb_idx] <= upd_tag;
      btb_tgt_q[upd_btb_idx] <= upd_target;
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-side producer of branch predictions for the rv32i pipeline: a bimodal branch history table (BHT) of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB).
- Fetch issues a PC lookup and receives a registered prediction one cycle later.
- Execute writes back the resolved outcome (the br_en from the branch comparator) and the computed target, training both tables.

Parameters:
BHT_IDX_BITS, 6, BHT entries = 2**BHT_IDX_BITS; index = pc[BHT_IDX_BITS+1:2]
BTB_IDX_BITS, 4, BTB entries = 2**BTB_IDX_BITS; index = pc[BTB_IDX_BITS+1:2]; tag = pc[31:BTB_IDX_BITS+2]

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
lkp_valid  input  1  fetch presents a PC for prediction this cycle
lkp_stall  input  1  fetch stalled; hold current prediction, accept no new lookup
lkp_pc  input  32  PC to predict
flush  input  1  pipeline redirect; discard held prediction
pred_valid  output  1  prediction registers hold a live response
pred_taken  output  1  predicted direction
pred_target  output  32  predicted next PC
upd_valid  input  1  execute resolved a conditional branch this cycle
upd_pc  input  32  PC of resolved branch
upd_taken  input  1  resolved direction (comparator br_en)
upd_target  input  32  resolved branch target

Behaviour:
- Reset (rst_n low, asynchronous):
  - pred_valid, pred_taken = 0; pred_target = 0.
  - Every BHT counter = 2'b01 (weakly not-taken); every BTB valid bit = 0.
  - Reset mid-operation discards any held prediction and all training.
- Lookup capture: at the rising edge, if lkp_valid && (!lkp_stall || flush), the outputs load from the table state before that edge's update. Latency is 1 cycle.
- Prediction rule:
  - hit = BTB valid && tag match.
  - pred_taken = BHT counter[1] && hit.
  - pred_target = BTB target if pred_taken, else lkp_pc + 4 (mod 2**32; 0xFFFFFFFC wraps to 0).
  - Counter taken but BTB miss -> predict not-taken.
- Hold: lkp_stall && !flush -> all outputs unchanged, lookup ignored.
- flush:
  - Overrides stall.
  - If lkp_valid is high in the same cycle, that lookup (the redirect PC) is captured normally.
  - Otherwise pred_valid = 0 next cycle; pred_taken and pred_target hold.
- No lookup, no stall, no flush: pred_valid = 0 next cycle.
- Update (upd_valid at edge):
  - BHT counter at upd_pc index: taken -> +1 saturating at 11; not-taken -> -1 saturating at 00.
  - If upd_taken: BTB entry written with valid = 1, tag, and upd_target, overwriting any alias.
  - If not-taken: BTB unchanged.
- Same-edge update and lookup to the same index: lookup sees the pre-update value (read-before-write); the update still commits.
- Updates are independent of lkp_stall and flush.
- pc[1:0] ignored everywhere.

Test Plan:
- Reset, then lookup 0x00001000 -> next cycle pred_valid = 1, pred_taken = 0, pred_target = 0x00001004; BHT[0] = 01, BTB[0] invalid.
- Two updates (pc 0x1000, taken, target 0x2000) -> counter 01->10->11. Lookup 0x1000 -> pred_taken = 1, pred_target = 0x00002000.
- Saturation: from 11 apply three not-taken (-> 00), then one not-taken (stays 00), then one taken (-> 01). Lookup 0x1000 -> pred_taken = 0, target 0x1004.
- Alias: train 0x1000 taken twice (target 0x2000). Lookup 0x1100 (same BHT index 0 and BTB index 0, different tag) -> counter 11 but BTB miss -> pred_taken = 0, target 0x1104.
- Stall and flush:
  - Lookup 0x1000 (trained), then stall 3 cycles with lkp_pc = 0x3000 -> outputs held at taken/0x2000.
  - flush with lkp_valid = 0 -> pred_valid = 0.
  - flush with lkp_valid = 1, pc 0x3000, lkp_stall = 1 -> captured, target 0x3004.
- Same-edge hazard and reset: with counter 01, update 0x1000 taken (target 0x2000) and lookup 0x1000 at the same edge -> pred_taken = 0. Repeat lookup -> counter 10 and BTB hit -> pred_taken = 1.
  - Then assert rst_n low mid-cycle -> outputs 0 immediately; post-reset lookup 0x1000 -> not-taken, 0x1004.
